// File: rtl/fp_accumulator.sv
// Front/back end for a combinational single-precision adder: accepts a counted
// stream of terms, accumulates them through the external adder and reports the sum.
module fp_accumulator #(
  parameter int N       = 32,
  parameter int COUNT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_sub,
  input  logic [N-1:0]       i_data,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  output logic [N-1:0]       o_add_a,
  output logic [N-1:0]       o_add_b,
  input  logic [N-1:0]       i_add_sum,
  output logic [N-1:0]       o_sum,
  output logic               o_done,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_acc;
  logic [N-1:0]       r_sum;
  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] r_count;
  logic               r_sub;
  logic               r_done;
  logic               r_busy;
  logic               r_ready;

  logic [N-1:0]       w_term;
  logic [N-1:0]       w_acc_next;
  logic [COUNT_W-1:0] w_cnt_next;
  logic               w_accept;

  assign w_term     = {i_data[N-1] ^ r_sub, i_data[N-2:0]};
  assign w_accept   = i_data_valid & r_ready;
  assign w_cnt_next = r_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};

  assign o_add_a      = r_acc;
  assign o_add_b      = w_term;
  assign o_sum        = r_sum;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_data_ready = r_ready;

  // Zero terms leave acc alone; a zero acc loads the term directly since the
  // adder always assumes a hidden 1.
  always_comb begin
    w_acc_next = r_acc;
    if (w_term[N-2:0] == {(N-1){1'b0}}) begin
      w_acc_next = r_acc;
    end else if (r_acc[N-2:0] == {(N-1){1'b0}}) begin
      w_acc_next = w_term;
    end else begin
      w_acc_next = i_add_sum;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= {N{1'b0}};
      r_sum   <= {N{1'b0}};
      r_cnt   <= {COUNT_W{1'b0}};
      r_count <= {COUNT_W{1'b0}};
      r_sub   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_count <= i_count;
            r_sub   <= i_sub;
            r_acc   <= {N{1'b0}};
            r_cnt   <= {COUNT_W{1'b0}};
            r_busy  <= 1'b1;
            if (i_count == {COUNT_W{1'b0}}) begin
              r_state <= S_DONE;
              r_sum   <= {N{1'b0}};
              r_done  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_ACC;
              r_ready <= 1'b1;
            end
          end else begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            if (w_cnt_next == r_count) begin
              r_state <= S_DONE;
              r_sum   <= w_acc_next;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_ACC;
            end
          end else begin
            r_state <= S_ACC;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator with a behavioural hidden-1 adder model.
module tb_fp_accumulator;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [3:0]  i_count;
  logic        i_sub;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [31:0] o_add_a;
  logic [31:0] o_add_b;
  logic [31:0] i_add_sum;
  logic [31:0] o_sum;
  logic        o_done;
  logic        o_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  fp_accumulator #(.N(32), .COUNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_count(i_count),
    .i_sub(i_sub), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .i_add_sum(i_add_sum), .o_sum(o_sum), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i < -e; i++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real a;
    int  e;
    logic [31:0] frac;
    if (r == 0.0) return 32'h0000_0000;
    a = (r < 0.0) ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    frac = 32'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {(r < 0.0) ? 1'b1 : 1'b0, e[7:0], frac[22:0]};
  endfunction

  // Adder with a hidden 1: zero operands produce junk that the DUT must not use.
  always_comb begin
    i_add_sum = 32'hDEAD_BEEF;
    if (o_add_a[30:0] != 31'd0 && o_add_b[30:0] != 31'd0)
      i_add_sum = r2f(f2r(o_add_a) + f2r(o_add_b));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every o_done pulse pops one expected sum.
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got o_done=1 expected no pending reduction");
      end else begin
        chk("sum", o_sum, exp_q.pop_front());
      end
    end
  end

  task automatic start(input logic [3:0] cnt, input logic sub);
    i_start = 1'b1; i_count = cnt; i_sub = sub;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic put(input logic [31:0] d);
    int k = 0;
    i_data = d; i_data_valid = 1'b1;
    while (!o_data_ready && k < 20) begin @(posedge i_clk); #1; k++; end
    if (k == 20) chk("ready_timeout", {31'd0, o_data_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_data_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_count = 4'd0; i_sub = 1'b0;
    i_data = 32'd0; i_data_valid = 1'b0;
    #12;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ready", {31'd0, o_data_ready}, 32'd0);
    chk("rst_sum", o_sum, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    i_rst_n = 1'b1;
    tick(2);

    // 1.0 + 2.0 + 3.0
    exp_q.push_back(32'h40C0_0000);
    start(4'd3, 1'b0);
    chk("t1_busy", {31'd0, o_busy}, 32'd1);
    put(32'h3F80_0000); put(32'h4000_0000); put(32'h4040_0000);
    chk("t1_done_latency", {31'd0, o_done}, 32'd1);
    tick(1);
    chk("t1_done_pulse", {31'd0, o_done}, 32'd0);
    chk("t1_busy_end", {31'd0, o_busy}, 32'd0);
    tick(1);

    // Subtract mode: -(1.0) - (0.5)
    exp_q.push_back(32'hBFC0_0000);
    start(4'd2, 1'b1);
    put(32'h3F80_0000);
    i_data = 32'h3F00_0000; #1;
    chk("t2_add_b", o_add_b, 32'hBF00_0000);
    put(32'h3F00_0000);
    tick(2);

    // Cancellation then reload
    exp_q.push_back(32'h4000_0000);
    start(4'd3, 1'b0);
    put(32'h3F80_0000); put(32'hBF80_0000);
    chk("t3_acc_zero", o_add_a, 32'h0000_0000);
    put(32'h4000_0000);
    tick(2);

    // Gaps, -0 term, ignored mid-run start
    exp_q.push_back(32'h4040_0000);
    start(4'd4, 1'b0);
    put(32'h8000_0000);
    chk("t4_neg_zero", o_add_a, 32'h0000_0000);
    tick(2);
    put(32'h4000_0000);
    tick(1);
    i_start = 1'b1; i_count = 4'd0;
    tick(1);
    i_start = 1'b0;
    chk("t4_gap_hold", o_add_a, 32'h4000_0000);
    chk("t4_start_ignored", {31'd0, o_busy}, 32'd1);
    put(32'h3F00_0000);
    tick(2);
    chk("t4_gap_hold2", o_add_a, 32'h4020_0000);
    put(32'h3F00_0000);
    tick(2);
    chk("t4_sum_held", o_sum, 32'h4040_0000);

    // Abort by reset after one of three terms
    start(4'd3, 1'b0);
    put(32'h3F80_0000);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, o_data_ready}, 32'd0);
    chk("t6_rst_sum", o_sum, 32'd0);
    chk("t6_rst_acc", o_add_a, 32'd0);
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
    exp_q.push_back(32'h4000_0000);
    start(4'd1, 1'b0);
    put(32'h4000_0000);
    tick(2);

    // Zero-length reduction
    exp_q.push_back(32'h0000_0000);
    start(4'd0, 1'b0);
    chk("t5_done", {31'd0, o_done}, 32'd1);
    chk("t5_ready", {31'd0, o_data_ready}, 32'd0);
    tick(1);
    chk("t5_done_pulse", {31'd0, o_done}, 32'd0);
    tick(3);

    chk("pending_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential front/back end for the combinational single-precision floating-point adder in the Maxnet datapath.
- Accepts a counted stream of IEEE-754 terms over a valid/ready handshake.
- Drives the adder's two operands (running sum, incoming term) and registers the adder's result back as the new running sum.
- Produces the reduced sum Σx_j, or −Σx_j in subtract mode, that the Maxnet update stage consumes.

Parameters:
- N, 32, word width of terms and sum (IEEE-754 single; only 32 is supported).
- COUNT_W, 4, width of the term-count field; up to 2^COUNT_W−1 terms per reduction.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  begin a reduction; sampled only in IDLE.
- i_count  input  COUNT_W  number of terms; latched with i_start.
- i_sub  input  1  1 = negate every term (sign-bit flip) before accumulation; latched with i_start.
- i_data  input  N  incoming term.
- i_data_valid  input  1  i_data is valid this cycle.
- o_data_ready  output  1  block accepts a term this cycle.
- o_add_a  output  N  adder operand 1; equals the running-sum register.
- o_add_b  output  N  adder operand 2; equals i_data with the sign flipped when sub mode is latched.
- i_add_sum  input  N  adder result, combinationally derived from o_add_a and o_add_b.
- o_sum  output  N  registered reduction result.
- o_done  output  1  one-cycle pulse; o_sum is final.
- o_busy  output  1  high outside IDLE.

Behaviour:
- Reset (asynchronous, while i_rst_n=0):
  - state=IDLE.
  - acc=0, o_sum=0, term counter=0, latched count=0, latched sub=0.
  - o_done=0, o_busy=0, o_data_ready=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - On i_start=1, latch i_count and i_sub, clear acc to 0x00000000, clear the term counter.
  - If i_count=0, go to DONE; otherwise go to ACC.
  - o_data_ready=0 in IDLE.
- ACC:
  - o_data_ready=1.
  - A term is accepted on an edge where i_data_valid=1 and o_data_ready=1. The effective term t is i_data, with bit 31 inverted when sub is latched.
  - Update on accept, in priority order:
    - t[30:0]=0 (±0): acc is unchanged.
    - acc[30:0]=0: acc <= t (bypasses the adder, which always assumes a hidden 1).
    - Otherwise: acc <= i_add_sum.
  - Each accept increments the term counter. When the incremented counter equals the latched count, go to DONE and load o_sum with the new acc value in the same edge.
  - Cycles with valid=0 hold all state; there is no timeout.
- DONE:
  - o_done=1 for exactly one cycle, then return to IDLE.
  - o_sum holds its value until the next reduction completes.
  - For count=0, o_sum=0x00000000.
- Throughput: one term per cycle. For c>0 terms accepted on consecutive cycles, o_done occurs 1 cycle after the last accept edge.
- o_add_a and o_add_b are driven continuously, including in IDLE and DONE. Downstream logic must ignore i_add_sum outside accept cycles.
- i_start is ignored while o_busy=1; there is no restart mid-reduction.
- Asserting reset during ACC or DONE aborts the reduction; no o_done is produced.
- Exact cancellation (the adder returns 0): acc becomes 0, and the next nonzero term loads directly into acc.
- The adder's exponent overflow and underflow behaviour passes through unmodified; the block performs no saturation.

Test Plan:
- Count 3, sub=0, terms 0x3F800000 (1.0), 0x40000000 (2.0), 0x40400000 (3.0) on consecutive cycles -> o_sum=0x40C00000 (6.0); o_done pulses once, 1 cycle after the 3rd accept; o_busy high from the cycle after start until o_done.
- Count 2, sub=1, terms 0x3F800000 (1.0), 0x3F000000 (0.5) -> o_sum=0xBFC00000 (−1.5); o_add_b shows 0xBF000000 on the 2nd accept.
- Count 3, terms 1.0, 0xBF800000 (−1.0), 2.0 -> acc=0 after the 2nd term; o_sum=0x40000000 (2.0), exercising cancellation and reload.
- Count 4 with gaps (valid low 2 cycles between terms), terms include 0x80000000 (−0), 2.0, 0.5, 0.5 -> o_sum=0x40400000 (3.0); acc holds during gaps and through the −0 term; i_start pulsed mid-run is ignored.
- i_count=0 with start -> DONE on the next cycle; o_done=1, o_sum=0x00000000, no term accepted.
- Assert i_rst_n=0 after 1 of 3 terms -> all outputs are zero immediately (asynchronous), state is IDLE, no o_done; a fresh count-1 run with 0x40000000 then yields o_sum=0x40000000.
